// File: rtl/trace_retire_collector.sv
// Two-lane retire trace collector: captures valid lane entries into an
// ordered FIFO and drains one per cycle over ready/valid; overflow drops are counted.
module trace_retire_collector #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_0_valid,
  input  logic [39:0]       in_0_iaddr,
  input  logic [31:0]       in_0_insn,
  input  logic [2:0]        in_0_priv,
  input  logic              in_0_exception,
  input  logic              in_0_interrupt,
  input  logic [63:0]       in_0_cause,
  input  logic [39:0]       in_0_tval,
  input  logic [63:0]       in_0_wdata,
  input  logic              in_1_valid,
  input  logic [39:0]       in_1_iaddr,
  input  logic [31:0]       in_1_insn,
  input  logic [2:0]        in_1_priv,
  input  logic              in_1_exception,
  input  logic              in_1_interrupt,
  input  logic [63:0]       in_1_cause,
  input  logic [39:0]       in_1_tval,
  input  logic [63:0]       in_1_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [39:0]       out_iaddr,
  output logic [31:0]       out_insn,
  output logic [2:0]        out_priv,
  output logic              out_exception,
  output logic              out_interrupt,
  output logic [63:0]       out_cause,
  output logic [39:0]       out_tval,
  output logic [63:0]       out_wdata,
  output logic              out_lane,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count,
  input  logic              drop_clear
);

  localparam int EW = 246;

  logic [EW-1:0]     mem_q [DEPTH];
  logic [EW-1:0]     mem_d [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              ovf_q, ovf_d;

  logic [EW-1:0]     e0, e1;
  logic [CW-1:0]     free;
  logic [AW-1:0]     wptr_n1;
  logic [1:0]        push, dropped;
  logic              pop;
  logic [DROP_W:0]   drop_sum;

  assign e0 = {1'b0, in_0_iaddr, in_0_insn, in_0_priv,
               in_0_exception, in_0_interrupt,
               in_0_cause, in_0_tval, in_0_wdata};
  assign e1 = {1'b1, in_1_iaddr, in_1_insn, in_1_priv,
               in_1_exception, in_1_interrupt,
               in_1_cause, in_1_tval, in_1_wdata};

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  // free is taken before this cycle's pop on purpose
  assign free      = CW'(DEPTH) - count_q;
  assign wptr_n1   = wptr_q + AW'(1);

  always_comb begin
    mem_d   = mem_q;
    push    = 2'd0;
    dropped = 2'd0;
    unique case (1'b1)
      (free == '0): begin
        dropped = {1'b0, in_0_valid} + {1'b0, in_1_valid};
      end
      (in_0_valid && in_1_valid && free == CW'(1)): begin
        mem_d[wptr_q] = e0;
        push          = 2'd1;
        dropped       = 2'd1;
      end
      default: begin
        if (in_0_valid && in_1_valid) begin
          mem_d[wptr_q]  = e0;
          mem_d[wptr_n1] = e1;
          push           = 2'd2;
        end else if (in_0_valid) begin
          mem_d[wptr_q] = e0;
          push          = 2'd1;
        end else if (in_1_valid) begin
          mem_d[wptr_q] = e1;
          push          = 2'd1;
        end
      end
    endcase
    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    drop_sum = {1'b0, drop_q} + (DROP_W + 1)'(dropped);
    drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    ovf_d    = ovf_q | (dropped != 2'd0);
    if (drop_clear) begin
      drop_d = '0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end

  assign {out_lane, out_iaddr, out_insn, out_priv,
          out_exception, out_interrupt,
          out_cause, out_tval, out_wdata} = mem_q[rptr_q];
  assign count      = count_q;
  assign drop_count = drop_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_trace_retire_collector.sv
// Directed bench for trace_retire_collector: ordering, overflow,
// saturation, clear, wrap-around and async reset.
module tb_trace_retire_collector;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic in_0_valid, in_1_valid;
  logic [39:0] in_0_iaddr, in_1_iaddr;
  logic [31:0] in_0_insn, in_1_insn;
  logic [2:0] in_0_priv, in_1_priv;
  logic in_0_exception, in_1_exception;
  logic in_0_interrupt, in_1_interrupt;
  logic [63:0] in_0_cause, in_1_cause;
  logic [39:0] in_0_tval, in_1_tval;
  logic [63:0] in_0_wdata, in_1_wdata;
  logic out_ready, drop_clear;

  logic out_valid, out_lane, out_exception, out_interrupt;
  logic [39:0] out_iaddr, out_tval;
  logic [31:0] out_insn;
  logic [2:0] out_priv;
  logic [63:0] out_cause, out_wdata;
  logic [3:0] count;
  logic overflow;
  logic [15:0] drop_count;

  logic d2_valid, d2_lane, d2_exc, d2_int;
  logic [39:0] d2_iaddr, d2_tval;
  logic [31:0] d2_insn;
  logic [2:0] d2_priv;
  logic [63:0] d2_cause, d2_wdata;
  logic [3:0] d2_count;
  logic d2_ovf;
  logic [1:0] d2_drop;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  trace_retire_collector #(.DEPTH(8), .DROP_W(16)) dut (
    .clock(clock), .reset(reset),
    .in_0_valid(in_0_valid), .in_0_iaddr(in_0_iaddr),
    .in_0_insn(in_0_insn), .in_0_priv(in_0_priv),
    .in_0_exception(in_0_exception),
    .in_0_interrupt(in_0_interrupt),
    .in_0_cause(in_0_cause), .in_0_tval(in_0_tval),
    .in_0_wdata(in_0_wdata),
    .in_1_valid(in_1_valid), .in_1_iaddr(in_1_iaddr),
    .in_1_insn(in_1_insn), .in_1_priv(in_1_priv),
    .in_1_exception(in_1_exception),
    .in_1_interrupt(in_1_interrupt),
    .in_1_cause(in_1_cause), .in_1_tval(in_1_tval),
    .in_1_wdata(in_1_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_iaddr(out_iaddr), .out_insn(out_insn),
    .out_priv(out_priv), .out_exception(out_exception),
    .out_interrupt(out_interrupt), .out_cause(out_cause),
    .out_tval(out_tval), .out_wdata(out_wdata),
    .out_lane(out_lane), .count(count),
    .overflow(overflow), .drop_count(drop_count),
    .drop_clear(drop_clear)
  );

  trace_retire_collector #(.DEPTH(8), .DROP_W(2)) dut2 (
    .clock(clock), .reset(reset),
    .in_0_valid(in_0_valid), .in_0_iaddr(in_0_iaddr),
    .in_0_insn(in_0_insn), .in_0_priv(in_0_priv),
    .in_0_exception(in_0_exception),
    .in_0_interrupt(in_0_interrupt),
    .in_0_cause(in_0_cause), .in_0_tval(in_0_tval),
    .in_0_wdata(in_0_wdata),
    .in_1_valid(in_1_valid), .in_1_iaddr(in_1_iaddr),
    .in_1_insn(in_1_insn), .in_1_priv(in_1_priv),
    .in_1_exception(in_1_exception),
    .in_1_interrupt(in_1_interrupt),
    .in_1_cause(in_1_cause), .in_1_tval(in_1_tval),
    .in_1_wdata(in_1_wdata),
    .out_valid(d2_valid), .out_ready(out_ready),
    .out_iaddr(d2_iaddr), .out_insn(d2_insn),
    .out_priv(d2_priv), .out_exception(d2_exc),
    .out_interrupt(d2_int), .out_cause(d2_cause),
    .out_tval(d2_tval), .out_wdata(d2_wdata),
    .out_lane(d2_lane), .count(d2_count),
    .overflow(d2_ovf), .drop_count(d2_drop),
    .drop_clear(drop_clear)
  );

  logic [245:0] head, head2;
  assign head = {out_lane, out_iaddr, out_insn, out_priv,
                 out_exception, out_interrupt,
                 out_cause, out_tval, out_wdata};
  assign head2 = {d2_lane, d2_iaddr, d2_insn, d2_priv,
                  d2_exc, d2_int, d2_cause, d2_tval, d2_wdata};

  task automatic check(string tag, logic [255:0] got,
                       logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] insn_of(logic [39:0] ia);
    return {12'h0, ia[19:0]} ^ 32'h13;
  endfunction

  function automatic logic [245:0] ent(bit l, logic [39:0] ia);
    return {l, ia, insn_of(ia), ia[4:2], ia[5], ia[6],
            {ia[23:0], ia}, ~ia, {ia[31:0], ~ia[31:0]}};
  endfunction

  task automatic drive(bit a, logic [39:0] ia,
                       bit b, logic [39:0] ib);
    in_0_valid = a; in_0_iaddr = ia;
    in_0_insn = insn_of(ia); in_0_priv = ia[4:2];
    in_0_exception = ia[5]; in_0_interrupt = ia[6];
    in_0_cause = {ia[23:0], ia}; in_0_tval = ~ia;
    in_0_wdata = {ia[31:0], ~ia[31:0]};
    in_1_valid = b; in_1_iaddr = ib;
    in_1_insn = insn_of(ib); in_1_priv = ib[4:2];
    in_1_exception = ib[5]; in_1_interrupt = ib[6];
    in_1_cause = {ib[23:0], ib}; in_1_tval = ~ib;
    in_1_wdata = {ib[31:0], ~ib[31:0]};
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 40'h0, 1'b0, 40'h0);
  endtask

  task automatic fill_dual(logic [39:0] base);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, base + 40'(8 * i), 1'b1, base + 40'(8 * i + 4));
      step();
    end
    idle();
  endtask

  task automatic drain_chk(logic [39:0] base, string tag);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check(tag, 256'(head), 256'(ent(k[0], base + 40'(4 * k))));
      step();
    end
    out_ready = 1'b0;
    check({tag, "_cnt"}, 256'(count), 256'(0));
  endtask

  task automatic single_entry(string tag);
    drive(1'b1, 40'h80000000, 1'b0, 40'h0);
    step();
    idle();
    check({tag, "_valid"}, 256'(out_valid), 256'(1));
    check({tag, "_iaddr"}, 256'(out_iaddr), 256'(40'h80000000));
    check({tag, "_insn"}, 256'(out_insn), 256'(32'h13));
    check({tag, "_lane"}, 256'(out_lane), 256'(0));
    check({tag, "_cnt"}, 256'(count), 256'(1));
    check({tag, "_head"}, 256'(head), 256'(ent(1'b0, 40'h80000000)));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_cnt0"}, 256'(count), 256'(0));
    check({tag, "_valid0"}, 256'(out_valid), 256'(0));
  endtask

  initial begin
    out_ready = 1'b0;
    drop_clear = 1'b0;
    idle();
    #1;
    check("rst_valid", 256'(out_valid), 256'(0));
    check("rst_cnt", 256'(count), 256'(0));
    check("rst_head", 256'(head), 256'(0));
    check("rst_drop", 256'(drop_count), 256'(0));
    check("rst_ovf", 256'(overflow), 256'(0));
    step();
    step();
    reset = 1'b1;
    step();

    single_entry("single");

    drive(1'b1, 40'h100, 1'b1, 40'h104);
    step();
    drive(1'b0, 40'h0, 1'b1, 40'h108);
    step();
    idle();
    check("ord_cnt", 256'(count), 256'(3));
    out_ready = 1'b1;
    check("ord_a", 256'(head), 256'(ent(1'b0, 40'h100)));
    step();
    check("ord_b", 256'(head), 256'(ent(1'b1, 40'h104)));
    step();
    check("ord_c", 256'(head), 256'(ent(1'b1, 40'h108)));
    step();
    out_ready = 1'b0;
    check("ord_cnt0", 256'(count), 256'(0));

    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 40'h200 + 40'(4 * i), 1'b0, 40'h0);
      step();
    end
    check("pov_cnt7", 256'(count), 256'(7));
    check("pov_ovf0", 256'(overflow), 256'(0));
    drive(1'b1, 40'h300, 1'b1, 40'h304);
    step();
    check("pov_cnt8", 256'(count), 256'(8));
    check("pov_drop1", 256'(drop_count), 256'(1));
    check("pov_ovf1", 256'(overflow), 256'(1));
    check("pov_d2drop1", 256'(d2_drop), 256'(1));
    drive(1'b1, 40'h400, 1'b1, 40'h404);
    step();
    check("pov_drop3", 256'(drop_count), 256'(3));
    check("pov_cnt8b", 256'(count), 256'(8));

    drive(1'b1, 40'h500, 1'b0, 40'h0);
    out_ready = 1'b1;
    check("fp_head", 256'(head), 256'(ent(1'b0, 40'h200)));
    step();
    idle();
    check("fp_cnt7", 256'(count), 256'(7));
    check("fp_drop4", 256'(drop_count), 256'(4));
    check("sat_d2", 256'(d2_drop), 256'(3));
    for (int k = 1; k < 7; k++) begin
      check("fp_drain", 256'(head), 256'(ent(1'b0, 40'h200 + 40'(4 * k))));
      step();
    end
    check("fp_l0keep", 256'(head), 256'(ent(1'b0, 40'h300)));
    step();
    out_ready = 1'b0;
    check("fp_cnt0", 256'(count), 256'(0));

    fill_dual(40'h600);
    check("clr_cnt8", 256'(count), 256'(8));
    drive(1'b1, 40'h700, 1'b0, 40'h0);
    step();
    check("sat_d2b", 256'(d2_drop), 256'(3));
    drive(1'b1, 40'h710, 1'b1, 40'h714);
    drop_clear = 1'b1;
    step();
    drop_clear = 1'b0;
    idle();
    check("clr_drop", 256'(drop_count), 256'(0));
    check("clr_ovf", 256'(overflow), 256'(0));
    check("clr_d2", 256'(d2_drop), 256'(0));
    check("clr_d2ovf", 256'(d2_ovf), 256'(0));
    drive(1'b1, 40'h720, 1'b0, 40'h0);
    step();
    idle();
    check("clr_drop1", 256'(drop_count), 256'(1));
    check("clr_ovf1", 256'(overflow), 256'(1));
    drain_chk(40'h600, "clr_drain");

    for (int r = 0; r < 3; r++) begin
      fill_dual(40'h1000 * 40'(r + 1));
      check("wrap_cnt8", 256'(count), 256'(8));
      check("wrap_d2cnt", 256'(d2_count), 256'(8));
      drain_chk(40'h1000 * 40'(r + 1), "wrap");
    end

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 40'h2000 + 40'(4 * i), 1'b0, 40'h0);
      step();
    end
    idle();
    check("ar_cnt5", 256'(count), 256'(5));
    #3;
    reset = 1'b0;
    #1;
    check("ar_valid", 256'(out_valid), 256'(0));
    check("ar_cnt", 256'(count), 256'(0));
    check("ar_head", 256'(head), 256'(0));
    check("ar_drop", 256'(drop_count), 256'(0));
    check("ar_ovf", 256'(overflow), 256'(0));
    check("ar_d2head", 256'(head2), 256'(0));
    step();
    reset = 1'b1;
    step();
    single_entry("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
